// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the fetch-side branch predictor:
// table entry layout, FSM states and 2-bit counter helpers.
package branch_predictor_pkg;

   localparam int unsigned BP_ENTRIES = 64;
   localparam int unsigned BP_TAG_W   = 8;

   typedef logic [31:0] virt_t;
   typedef logic [1:0]  bp_ctr_t;

   localparam bp_ctr_t BP_CTR_SNT = 2'b00;
   localparam bp_ctr_t BP_CTR_WNT = 2'b01;
   localparam bp_ctr_t BP_CTR_WT  = 2'b10;
   localparam bp_ctr_t BP_CTR_ST  = 2'b11;

   typedef struct packed {
      logic                valid;
      logic [BP_TAG_W-1:0] tag;
      virt_t               target;
      bp_ctr_t             ctr;
   } bp_entry_t;

   typedef enum logic {
      BP_INIT = 1'b0,
      BP_RUN  = 1'b1
   } bp_state_e;

   // Saturating step of a 2-bit direction counter.
   function automatic bp_ctr_t bp_ctr_next(input bp_ctr_t ctr, input logic taken);
      bp_ctr_t nxt;
      nxt = ctr;
      if (taken && (ctr != BP_CTR_ST)) begin
         nxt = ctr + 2'b01;
      end else if (!taken && (ctr != BP_CTR_SNT)) begin
         nxt = ctr - 2'b01;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/bp_table_ram.sv
// Predictor table storage: one registered read port (write-first on collision)
// and one write port whose current contents are visible for read-modify-write.
module bp_table_ram
   import branch_predictor_pkg::*;
#(
   parameter int unsigned ENTRIES = BP_ENTRIES,
   parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             rd_en_i,
   input  logic [IDX_W-1:0] rd_idx_i,
   output bp_entry_t        rd_data_o,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  bp_entry_t        wr_data_i,
   input  logic [IDX_W-1:0] rmw_idx_i,
   output bp_entry_t        rmw_data_c_o
);

   bp_entry_t mem_q [ENTRIES];
   bp_entry_t rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_idx_i] <= wr_data_i;
      end
      if (rd_en_i) begin
         rd_data_q <= (wr_en_i && (wr_idx_i == rd_idx_i)) ? wr_data_i : mem_q[rd_idx_i];
      end
   end

   assign rd_data_o    = rd_data_q;
   assign rmw_data_c_o = mem_q[rmw_idx_i];

endmodule

// File: rtl/branch_predictor.sv
// BTB with 2-bit saturating direction counters: INIT sweep clears the table,
// RUN serves 1-cycle lookups and trains from execute-stage outcomes.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int unsigned ENTRIES = BP_ENTRIES,
   parameter int unsigned TAG_W   = BP_TAG_W
) (
   input  logic  clk,
   input  logic  resetn,
   input  logic  bp_flush,
   output logic  bp_ready,
   input  logic  lk_valid,
   input  logic  lk_stall,
   input  virt_t lk_pc,
   output logic  predict_hit,
   output logic  predict_is_taken,
   output virt_t predict_target,
   input  logic  upd_valid,
   input  virt_t upd_pc,
   input  logic  upd_taken,
   input  virt_t upd_target
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);

   bp_state_e           state_q, state_d;
   logic [IDX_W-1:0]    sweep_q, sweep_d;
   logic                ready_q;
   logic                lk_valid_q, lk_valid_d;
   logic [BP_TAG_W-1:0] lk_tag_q, lk_tag_d;

   logic [IDX_W-1:0]    lk_idx, upd_idx, wr_idx;
   logic [BP_TAG_W-1:0] lk_tag, upd_tag;
   logic                rd_en, wr_en, upd_hit, hit_c;
   bp_entry_t           rd_entry, rmw_entry, wr_data;
   logic                unused_pc_bits;

   assign lk_idx  = lk_pc[IDX_W+1:2];
   assign upd_idx = upd_pc[IDX_W+1:2];
   assign lk_tag  = BP_TAG_W'(lk_pc[IDX_W+TAG_W+1:IDX_W+2]);
   assign upd_tag = BP_TAG_W'(upd_pc[IDX_W+TAG_W+1:IDX_W+2]);
   assign unused_pc_bits = ^{lk_pc[31:IDX_W+TAG_W+2], lk_pc[1:0],
                             upd_pc[31:IDX_W+TAG_W+2], upd_pc[1:0]};

   // A stalled fetch keeps the read register untouched so the prediction holds.
   assign rd_en = lk_valid && !lk_stall;

   bp_table_ram #(
      .ENTRIES (ENTRIES),
      .IDX_W   (IDX_W)
   ) u_table (
      .clk          (clk),
      .rd_en_i      (rd_en),
      .rd_idx_i     (lk_idx),
      .rd_data_o    (rd_entry),
      .wr_en_i      (wr_en),
      .wr_idx_i     (wr_idx),
      .wr_data_i    (wr_data),
      .rmw_idx_i    (upd_idx),
      .rmw_data_c_o (rmw_entry)
   );

   assign upd_hit = rmw_entry.valid && (rmw_entry.tag == upd_tag);

   // Next state, table write selection and lookup-tracking registers.
   always_comb begin
      state_d    = state_q;
      sweep_d    = sweep_q;
      wr_en      = 1'b0;
      wr_idx     = upd_idx;
      wr_data    = '0;
      lk_valid_d = lk_valid_q;
      lk_tag_d   = lk_tag_q;

      case (state_q)
         BP_INIT: begin
            wr_en       = 1'b1;
            wr_idx      = sweep_q;
            wr_data.ctr = BP_CTR_WNT;
            sweep_d     = sweep_q + IDX_W'(1);
            if (sweep_q == IDX_W'(ENTRIES - 1)) begin
               state_d = BP_RUN;
            end
         end
         BP_RUN: begin
            if (upd_valid && !bp_flush) begin
               if (upd_hit) begin
                  wr_en       = 1'b1;
                  wr_data     = rmw_entry;
                  wr_data.ctr = bp_ctr_next(rmw_entry.ctr, upd_taken);
                  if (upd_taken) begin
                     wr_data.target = upd_target;
                  end
               end else if (upd_taken) begin
                  wr_en          = 1'b1;
                  wr_data.valid  = 1'b1;
                  wr_data.tag    = upd_tag;
                  wr_data.target = upd_target;
                  wr_data.ctr    = BP_CTR_WT;
               end
            end
         end
         default: state_d = BP_INIT;
      endcase

      if (!lk_stall) begin
         lk_valid_d = lk_valid && (state_q == BP_RUN);
         lk_tag_d   = lk_tag;
      end

      if (bp_flush) begin
         state_d    = BP_INIT;
         sweep_d    = '0;
         lk_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= BP_INIT;
         sweep_q    <= '0;
         ready_q    <= 1'b0;
         lk_valid_q <= 1'b0;
         lk_tag_q   <= '0;
      end else begin
         state_q    <= state_d;
         sweep_q    <= sweep_d;
         ready_q    <= (state_d == BP_RUN);
         lk_valid_q <= lk_valid_d;
         lk_tag_q   <= lk_tag_d;
      end
   end

   assign hit_c            = lk_valid_q && rd_entry.valid && (rd_entry.tag == lk_tag_q);
   assign predict_hit      = hit_c;
   assign predict_is_taken = hit_c && rd_entry.ctr[1];
   assign predict_target   = hit_c ? rd_entry.target : '0;
   assign bp_ready         = ready_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios plus random traffic, all
// checked every cycle against an array-based behavioural model.
module tb_branch_predictor;

   localparam int NENT = 64;

   logic        clk = 1'b0;
   logic        resetn, bp_flush, bp_ready;
   logic        lk_valid, lk_stall;
   logic [31:0] lk_pc;
   logic        predict_hit, predict_is_taken;
   logic [31:0] predict_target;
   logic        upd_valid, upd_taken;
   logic [31:0] upd_pc, upd_target;

   branch_predictor dut (
      .clk              (clk),
      .resetn           (resetn),
      .bp_flush         (bp_flush),
      .bp_ready         (bp_ready),
      .lk_valid         (lk_valid),
      .lk_stall         (lk_stall),
      .lk_pc            (lk_pc),
      .predict_hit      (predict_hit),
      .predict_is_taken (predict_is_taken),
      .predict_target   (predict_target),
      .upd_valid        (upd_valid),
      .upd_pc           (upd_pc),
      .upd_taken        (upd_taken),
      .upd_target       (upd_target)
   );

   always #5 clk = ~clk;

   // Behavioural model: table contents, cycles left in init, expected outputs.
   bit          m_valid [NENT];
   logic [7:0]  m_tag   [NENT];
   logic [31:0] m_tgt   [NENT];
   int          m_ctr   [NENT];
   int          m_left;
   bit          e_hit, e_taken;
   logic [31:0] e_tgt;
   int          n_tests = 0;
   int          n_fail  = 0;

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 2) % 32'(NENT));
   endfunction

   function automatic logic [7:0] tag_of(input logic [31:0] pc);
      return 8'((pc >> 8) % 32'd256);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NENT; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = '0;
         m_tgt[i]   = '0;
         m_ctr[i]   = 1;
      end
      m_left = NENT;
      e_hit = 1'b0; e_taken = 1'b0; e_tgt = '0;
   endtask

   task automatic model_update();
      int i;
      i = idx_of(upd_pc);
      if (m_valid[i] && m_tag[i] == tag_of(upd_pc)) begin
         if (upd_taken) begin
            m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
            m_tgt[i] = upd_target;
         end else begin
            m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
         end
      end else if (upd_taken) begin
         m_valid[i] = 1'b1;
         m_tag[i]   = tag_of(upd_pc);
         m_tgt[i]   = upd_target;
         m_ctr[i]   = 2;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   // Advance one clock with the currently driven inputs and check all outputs.
   task automatic tick();
      bit run;
      int i;
      run = (m_left == 0);
      if (!resetn || bp_flush) begin
         model_clear();
      end else begin
         if (run && upd_valid) model_update();
         if (!lk_stall) begin
            if (lk_valid && run) begin
               i       = idx_of(lk_pc);
               e_hit   = m_valid[i] && (m_tag[i] == tag_of(lk_pc));
               e_taken = e_hit && (m_ctr[i] >= 2);
               e_tgt   = e_hit ? m_tgt[i] : 32'h0;
            end else begin
               e_hit = 1'b0; e_taken = 1'b0; e_tgt = '0;
            end
         end
         if (m_left > 0) m_left--;
      end
      @(posedge clk);
      @(negedge clk);
      chk("ready",  {31'b0, bp_ready},         {31'b0, m_left == 0});
      chk("hit",    {31'b0, predict_hit},      {31'b0, e_hit});
      chk("taken",  {31'b0, predict_is_taken}, {31'b0, e_taken});
      chk("target", predict_target,            e_tgt);
   endtask

   task automatic idle();
      lk_valid = 1'b0; lk_stall = 1'b0; upd_valid = 1'b0; bp_flush = 1'b0;
      lk_pc = '0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
   endtask

   task automatic lookup(input logic [31:0] pc);
      lk_valid = 1'b1; lk_pc = pc;
      tick();
      lk_valid = 1'b0;
   endtask

   task automatic update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
      upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
      tick();
      upd_valid = 1'b0;
   endtask

   function automatic logic [31:0] rnd_pc();
      logic [31:0] pc;
      pc       = $urandom;
      pc[15:8] = 8'($urandom_range(0, 3));
      pc[7:2]  = 6'($urandom_range(0, 7));
      pc[1:0]  = 2'b00;
      return pc;
   endfunction

   initial begin
      idle();
      resetn = 1'b0;
      model_clear();
      repeat (3) tick();
      chk("rst_ready", {31'b0, bp_ready}, 32'h0);
      chk("rst_hit", {31'b0, predict_hit}, 32'h0);

      // Init sweep: ready rises on exactly the 64th edge; INIT lookups are zero.
      resetn = 1'b1;
      for (int c = 1; c <= NENT; c++) begin
         if (c == 10) begin
            lk_valid = 1'b1; lk_pc = 32'hBFC0_0100;
         end
         tick();
         lk_valid = 1'b0;
         if (c == 10) chk("init_lookup_tgt", predict_target, 32'h0);
         if (c == 63) chk("ready_c63", {31'b0, bp_ready}, 32'h0);
         if (c == 64) chk("ready_c64", {31'b0, bp_ready}, 32'h1);
      end

      // Cold miss, allocate, then hit with ctr=WT.
      lookup(32'hBFC0_0100);
      chk("cold_hit", {31'b0, predict_hit}, 32'h0);
      update(32'hBFC0_0100, 1'b1, 32'hBFC0_0200);
      lookup(32'hBFC0_0100);
      chk("alloc_hit", {31'b0, predict_hit}, 32'h1);
      chk("alloc_taken", {31'b0, predict_is_taken}, 32'h1);
      chk("alloc_tgt", predict_target, 32'hBFC0_0200);

      // Counter saturates low, then climbs back to WT.
      repeat (3) update(32'hBFC0_0100, 1'b0, 32'h0);
      lookup(32'hBFC0_0100);
      chk("snt_hit", {31'b0, predict_hit}, 32'h1);
      chk("snt_taken", {31'b0, predict_is_taken}, 32'h0);
      repeat (2) update(32'hBFC0_0100, 1'b1, 32'hBFC0_0200);
      lookup(32'hBFC0_0100);
      chk("wt_taken", {31'b0, predict_is_taken}, 32'h1);

      // Same-cycle lookup and allocating update: write-first.
      lk_valid = 1'b1; lk_pc = 32'h0000_2040;
      update(32'h0000_2040, 1'b1, 32'h8000_1000);
      lk_valid = 1'b0;
      chk("wf_hit", {31'b0, predict_hit}, 32'h1);
      chk("wf_tgt", predict_target, 32'h8000_1000);

      // Aliasing on one index: second allocation evicts the first.
      update(32'h0000_0010, 1'b1, 32'h0000_AAA0);
      update(32'h0000_0410, 1'b1, 32'h0000_BBB0);
      lookup(32'h0000_0010);
      chk("alias_miss", {31'b0, predict_hit}, 32'h0);
      lookup(32'h0000_0410);
      chk("alias_tgt", predict_target, 32'h0000_BBB0);

      // Stall holds the prediction even across training; unstalled idle clears it.
      lookup(32'hBFC0_0100);
      lk_stall = 1'b1;
      update(32'hBFC0_0100, 1'b1, 32'h1234_5678);
      chk("stall_tgt", predict_target, 32'hBFC0_0200);
      lk_stall = 1'b0;
      tick();
      chk("unstall_hit", {31'b0, predict_hit}, 32'h0);

      // Flush with a trained entry; training during INIT is ignored.
      bp_flush = 1'b1;
      tick();
      bp_flush = 1'b0;
      for (int c = 1; c <= NENT; c++) begin
         if (c == 5) begin
            upd_valid = 1'b1; upd_pc = 32'h0000_0300; upd_taken = 1'b1; upd_target = 32'h0000_0900;
         end
         tick();
         upd_valid = 1'b0;
         if (c == 63) chk("flush_ready_c63", {31'b0, bp_ready}, 32'h0);
      end
      chk("flush_ready", {31'b0, bp_ready}, 32'h1);
      lookup(32'hBFC0_0100);
      chk("flush_miss", {31'b0, predict_hit}, 32'h0);
      lookup(32'h0000_0300);
      chk("init_upd_miss", {31'b0, predict_hit}, 32'h0);

      // Random traffic on a small PC pool so hits, aliasing and collisions are common.
      for (int n = 0; n < 1500; n++) begin
         lk_valid   = ($urandom_range(0, 3) != 0);
         lk_stall   = ($urandom_range(0, 7) == 0);
         lk_pc      = rnd_pc();
         upd_valid  = $urandom_range(0, 1) == 1;
         upd_pc     = ($urandom_range(0, 3) == 0) ? lk_pc : rnd_pc();
         upd_taken  = $urandom_range(0, 1) == 1;
         upd_target = $urandom;
         bp_flush   = ($urandom_range(0, 299) == 0);
         tick();
      end
      idle();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
